// File: rtl/key_pkg.sv
// Shared definitions for the pushbutton conditioner.
// Contents: per-channel FSM state encoding, default timing constants
// (50 MHz system clock) and a small max helper used to size counters.
package key_pkg;

  typedef enum logic [1:0] {
    RELEASED  = 2'd0,
    HELD      = 2'd1,
    REPEATING = 2'd2
  } key_state_e;

  localparam int DEF_N_KEYS          = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 1000000;   // 20 ms
  localparam int DEF_REPEAT_DELAY    = 25000000;  // 500 ms
  localparam int DEF_REPEAT_PERIOD   = 10000000;  // 200 ms

  // Largest of three timing constants; sizes the shared counter width.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) begin
      m = b;
    end else begin
      m = m;
    end
    if (c > m) begin
      m = c;
    end else begin
      m = m;
    end
    return m;
  endfunction

endpackage

// File: rtl/key_conditioner_if.sv
// Pushbutton bus between the raw keys and the digit-entry logic.
// Signals:
//   KEY       raw pushbuttons, active-low, asynchronous
//   key_level debounced level, active-high
//   key_pulse one-cycle press pulse per channel
// Modports: master drives KEY (board / bench), slave is the conditioner.
interface key_conditioner_if #(
  parameter int N_KEYS = 2
) ();

  logic [N_KEYS-1:0] KEY;
  logic [N_KEYS-1:0] key_level;
  logic [N_KEYS-1:0] key_pulse;

  modport master (output KEY, input key_level, input key_pulse);
  modport slave  (input KEY, output key_level, output key_pulse);

endinterface

// File: rtl/key_debounce_ch.sv
// Single pushbutton channel: 2-flop synchroniser, debounce counter and
// RELEASED/HELD/REPEATING state machine producing a registered level and
// a registered one-cycle press pulse.
// Optional feature: define KEY_AUTOREPEAT_EN to build the auto-repeat
// counter (first repeat after REPEAT_DELAY held cycles, then every
// REPEAT_PERIOD cycles). Without it REPEATING is unreachable.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous reset, active-low
//   key_n  raw key, active-low, asynchronous
//   level  debounced level, active-high
//   pulse  one-cycle pulse on accepted press (and on repeats if enabled)
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic level,
  output logic pulse
);

  localparam int CNT_W = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD) + 1);
  localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic [1:0]       sync_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             toggle_s;
  logic             pressed_s;
  key_state_e       state_r;
  key_state_e       state_nxt_s;
  logic             level_r;
  logic             pulse_r;
  logic             pulse_nxt_s;

`ifdef KEY_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);
  logic [CNT_W-1:0] rep_cnt_r;
  logic [CNT_W-1:0] rep_nxt_s;
`endif

  // Synchroniser; resets to the released (high) level of the raw key.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], key_n};
    end
  end

  assign pressed_s = ~sync_r[1];

  // Debounce counter: toggle is taken on the edge after DEBOUNCE_CYCLES
  // consecutive differing samples have been counted.
  always_comb begin
    cnt_nxt_s = '0;
    toggle_s  = 1'b0;
    if (cnt_r == DB_MAX) begin
      toggle_s  = 1'b1;
      cnt_nxt_s = '0;
    end else if (pressed_s != level_r) begin
      cnt_nxt_s = cnt_r + CNT_W'(1'b1);
    end else begin
      cnt_nxt_s = '0;
    end
  end

  // Next-state and pulse decode.
  always_comb begin
    state_nxt_s = state_r;
    pulse_nxt_s = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
    rep_nxt_s   = '0;
`endif
    case (state_r)
      RELEASED: begin
        if (toggle_s) begin
          state_nxt_s = HELD;
          pulse_nxt_s = 1'b1;
        end else begin
          state_nxt_s = RELEASED;
        end
      end
      HELD: begin
        if (toggle_s) begin
          state_nxt_s = RELEASED;
        end else begin
`ifdef KEY_AUTOREPEAT_EN
          if (rep_cnt_r == RD_LAST) begin
            state_nxt_s = REPEATING;
            pulse_nxt_s = 1'b1;
          end else begin
            rep_nxt_s = rep_cnt_r + CNT_W'(1'b1);
          end
`else
          state_nxt_s = HELD;
`endif
        end
      end
      REPEATING: begin
        if (toggle_s) begin
          state_nxt_s = RELEASED;
        end else begin
`ifdef KEY_AUTOREPEAT_EN
          if (rep_cnt_r == RP_LAST) begin
            pulse_nxt_s = 1'b1;
          end else begin
            rep_nxt_s = rep_cnt_r + CNT_W'(1'b1);
          end
`else
          // Unreachable in this build; fall back to a safe state.
          state_nxt_s = RELEASED;
`endif
        end
      end
      default: begin
        state_nxt_s = RELEASED;
      end
    endcase
  end

  // Channel state, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r     <= '0;
      state_r   <= RELEASED;
      level_r   <= 1'b0;
      pulse_r   <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
      rep_cnt_r <= '0;
`endif
    end else begin
      cnt_r     <= cnt_nxt_s;
      state_r   <= state_nxt_s;
      level_r   <= (state_nxt_s != RELEASED);
      pulse_r   <= pulse_nxt_s;
`ifdef KEY_AUTOREPEAT_EN
      rep_cnt_r <= rep_nxt_s;
`endif
    end
  end

  assign level = level_r;
  assign pulse = pulse_r;

endmodule

// File: rtl/key_conditioner.sv
// Pushbutton conditioner: N_KEYS independent debounce channels.
// Optional feature macro: KEY_AUTOREPEAT_EN (auto-repeat pulses while held).
// Ports:
//   CLOCK_50  system clock, rising edge
//   reset     asynchronous reset, active-low
//   keys      key_conditioner_if.slave: KEY in, key_level / key_pulse out
//             (key_pulse bit 1 = digit increment, bit 0 = position advance)
module key_conditioner
  import key_pkg::*;
#(
  parameter int N_KEYS          = DEF_N_KEYS,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  key_conditioner_if.slave keys
);

  logic [N_KEYS-1:0] level_s;
  logic [N_KEYS-1:0] pulse_s;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .clk  (CLOCK_50),
      .rst_n(reset),
      .key_n(keys.KEY[i]),
      .level(level_s[i]),
      .pulse(pulse_s[i])
    );
  end

  assign keys.key_level = level_s;
  assign keys.key_pulse = pulse_s;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=10, REPEAT_PERIOD=5. Edge 0 is the first rising edge that
// samples the new KEY value; outputs are sampled 1 time unit after each edge.
module tb_key_conditioner;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  key_conditioner_if #(.N_KEYS(2)) bus ();

  key_conditioner #(
    .N_KEYS         (2),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (5)
  ) dut (
    .CLOCK_50(clk),
    .reset   (reset),
    .keys    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] exp_p;
    tests   = 0;
    fails   = 0;
    reset   = 1'b0;
    bus.KEY = 2'b11;

    // Reset state.
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("rst_level_%0d", k), bus.key_level, 2'b00);
      check($sformatf("rst_pulse_%0d", k), bus.key_pulse, 2'b00);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
    end
    check("idle_level", bus.key_level, 2'b00);

    // Clean press on KEY[1] held 20 cycles, then release.
    bus.KEY = 2'b01;
    for (int k = 0; k < 20; k++) begin
      tick();
      check($sformatf("t1_pulse_e%0d", k), bus.key_pulse, (k == 6) ? 2'b10 : 2'b00);
      check($sformatf("t1_level_e%0d", k), bus.key_level, (k >= 6) ? 2'b10 : 2'b00);
    end
    bus.KEY = 2'b11;
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("t1r_pulse_e%0d", k), bus.key_pulse, 2'b00);
      check($sformatf("t1r_level_e%0d", k), bus.key_level, (k < 6) ? 2'b10 : 2'b00);
    end

    // Bounce on KEY[0]: toggles every 2 cycles for 12 cycles.
    for (int k = 0; k < 20; k++) begin
      bus.KEY = (k < 12 && (k % 4) < 2) ? 2'b10 : 2'b11;
      tick();
      check($sformatf("t2_pulse_e%0d", k), bus.key_pulse, 2'b00);
      check($sformatf("t2_level_e%0d", k), bus.key_level, 2'b00);
    end

    // Simultaneous press on both keys.
    bus.KEY = 2'b00;
    for (int k = 0; k < 14; k++) begin
      tick();
      check($sformatf("t3_pulse_e%0d", k), bus.key_pulse, (k == 6) ? 2'b11 : 2'b00);
    end
    check("t3_level", bus.key_level, 2'b11);
    bus.KEY = 2'b11;
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("t3r_pulse_e%0d", k), bus.key_pulse, 2'b00);
      check($sformatf("t3r_level_e%0d", k), bus.key_level, (k < 6) ? 2'b11 : 2'b00);
    end

    // Long hold on KEY[1]: repeat pattern depends on the build.
    bus.KEY = 2'b01;
    for (int k = 0; k < 31; k++) begin
      tick();
`ifdef KEY_AUTOREPEAT_EN
      exp_p = (k == 6 || k == 16 || k == 21 || k == 26) ? 2'b10 : 2'b00;
`else
      exp_p = (k == 6) ? 2'b10 : 2'b00;
`endif
      check($sformatf("t4_pulse_e%0d", k), bus.key_pulse, exp_p);
    end
    bus.KEY = 2'b11;
    for (int k = 0; k < 12; k++) begin
      tick();
    end
    check("t4_level_released", bus.key_level, 2'b00);

    // Reset mid-debounce with KEY[0] held through reset release.
    bus.KEY = 2'b10;
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("t5_rst_level", bus.key_level, 2'b00);
    check("t5_rst_pulse", bus.key_pulse, 2'b00);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("t5_inrst_pulse_%0d", k), bus.key_pulse, 2'b00);
      check($sformatf("t5_inrst_level_%0d", k), bus.key_level, 2'b00);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 11; k++) begin
      tick();
      check($sformatf("t5_pulse_e%0d", k), bus.key_pulse, (k == 6) ? 2'b01 : 2'b00);
      check($sformatf("t5_level_e%0d", k), bus.key_level, (k >= 6) ? 2'b01 : 2'b00);
    end
    bus.KEY = 2'b11;
    for (int k = 0; k < 10; k++) begin
      tick();
    end
    check("t5_level_released", bus.key_level, 2'b00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
